// File: rtl/hist_peak_builder.sv
// Per-pixel TDC histogram builder: accumulates ACQ_NUM shots into bin counters,
// then scans every bin once to extract each pixel's peak and clears it for the next frame.
module hist_peak_builder #(
  parameter int DATA_W    = 10,
  parameter int BIN_SHIFT = 2,
  parameter int PIXELS    = 3,
  parameter int ACQ_NUM   = 4,
  parameter int CNT_W     = 8
) (
  input  logic                                clk,
  input  logic                                res,
  input  logic                                wr_en,
  input  logic                                sync,
  input  logic [DATA_W-1:0]                   data,
  output logic                                in_ready,
  output logic [PIXELS*(DATA_W-BIN_SHIFT)-1:0] peak_bin,
  output logic [PIXELS*CNT_W-1:0]             peak_cnt,
  output logic [PIXELS-1:0]                   sat_flag,
  output logic                                result_valid
);

  localparam int BIN_W = DATA_W - BIN_SHIFT;
  localparam int BINS  = 1 << BIN_W;
  localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_NUM - 1);

  typedef enum logic {ACCUM, SCAN} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] hist [PIXELS][BINS];
  logic [PIX_W-1:0] pix, eff_pix, scan_pix;
  logic [ACQ_W-1:0] acq;
  logic [BIN_W-1:0] bin_idx, scan_bin, run_bin;
  logic [CNT_W-1:0] run_max, cur;
  logic [PIXELS-1:0] sat_acc;
  logic accept, pix_last, frame_done, hit, at_max;
  logic scan_last_bin, scan_done, take;

  // A sync sample is always pixel 0, whatever the counter said.
  assign eff_pix    = sync ? '0 : pix;
  assign accept     = (state == ACCUM) && wr_en;
  assign pix_last   = (eff_pix == PIX_LAST);
  assign frame_done = accept && pix_last && (acq == ACQ_LAST);
  assign bin_idx    = data[DATA_W-1:BIN_SHIFT];
  assign hit        = accept && (data != '0);
  assign at_max     = (hist[eff_pix][bin_idx] == {CNT_W{1'b1}});

  assign scan_last_bin = (scan_bin == {BIN_W{1'b1}});
  assign scan_done     = (state == SCAN) && scan_last_bin && (scan_pix == PIX_LAST);
  assign cur           = hist[scan_pix][scan_bin];
  // Strictly greater keeps the lowest bin index on ties.
  assign take          = (cur > run_max);

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (frame_done) state_next = SCAN;
      SCAN:  if (scan_done)  state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready = (state == ACCUM);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pix      <= '0;
      acq      <= '0;
      scan_pix <= '0;
      scan_bin <= '0;
      run_max  <= '0;
      run_bin  <= '0;
    end else if (state == ACCUM) begin
      if (accept) begin
        pix <= pix_last ? '0 : eff_pix + 1'b1;
        if (frame_done)
          acq <= '0;
        else if (pix_last && !sync)
          acq <= acq + 1'b1;
      end else if (sync) begin
        pix <= '0;
      end
    end else begin
      scan_bin <= scan_bin + 1'b1;
      if (scan_last_bin) begin
        scan_pix <= (scan_pix == PIX_LAST) ? '0 : scan_pix + 1'b1;
        run_max  <= '0;
        run_bin  <= '0;
      end else if (take) begin
        run_max <= cur;
        run_bin <= scan_bin;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int p = 0; p < PIXELS; p++)
        for (int b = 0; b < BINS; b++)
          hist[p][b] <= '0;
    end else if (hit && !at_max) begin
      hist[eff_pix][bin_idx] <= hist[eff_pix][bin_idx] + 1'b1;
    end else if (state == SCAN) begin
      hist[scan_pix][scan_bin] <= '0;
    end
  end

  // Results: peaks latch per pixel at its last bin, saturation flags at frame end.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      peak_bin     <= '0;
      peak_cnt     <= '0;
      sat_flag     <= '0;
      sat_acc      <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= scan_done;
      if (hit && at_max)
        sat_acc[eff_pix] <= 1'b1;
      if ((state == SCAN) && scan_last_bin) begin
        peak_bin[scan_pix*BIN_W +: BIN_W] <= take ? scan_bin : run_bin;
        peak_cnt[scan_pix*CNT_W +: CNT_W] <= take ? cur : run_max;
      end
      if (scan_done) begin
        sat_flag <= sat_acc;
        sat_acc  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hist_peak_builder.sv
// Directed bench for hist_peak_builder: table of whole frames plus hand-written
// sync, SCAN-drop and reset sequences; a CNT_W=2 twin covers saturation.
module tb_hist_peak_builder;

  localparam int LATENCY = 3*256 + 1;

  logic clk = 1'b0;
  logic res, wr_en, sync;
  logic [9:0]  data;
  logic        in_ready, result_valid, in_ready2, result_valid2;
  logic [23:0] peak_bin, peak_cnt, peak_bin2;
  logic [5:0]  peak_cnt2;
  logic [2:0]  sat_flag, sat_flag2;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  hist_peak_builder dut (
    .clk(clk), .res(res), .wr_en(wr_en), .sync(sync), .data(data),
    .in_ready(in_ready), .peak_bin(peak_bin), .peak_cnt(peak_cnt),
    .sat_flag(sat_flag), .result_valid(result_valid)
  );

  hist_peak_builder #(.CNT_W(2)) dut_sat (
    .clk(clk), .res(res), .wr_en(wr_en), .sync(sync), .data(data),
    .in_ready(in_ready2), .peak_bin(peak_bin2), .peak_cnt(peak_cnt2),
    .sat_flag(sat_flag2), .result_valid(result_valid2)
  );

  typedef struct packed {
    logic [2:0][3:0][9:0] p;
    logic [2:0][7:0]      ebin;
    logic [2:0][7:0]      ecnt;
    logic [2:0]           esat;
  } vec_t;

  vec_t tbl [5];
  logic [2:0][3:0][9:0] zero_frame;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sendSample(input logic [9:0] d, input logic s);
    @(negedge clk);
    wr_en = 1'b1;
    sync  = s;
    data  = d;
  endtask

  task automatic applyStimulus(input logic [2:0][3:0][9:0] p, input logic first_sync);
    for (int shot = 0; shot < 4; shot++)
      for (int px = 0; px < 3; px++)
        sendSample(p[px][shot], first_sync && shot == 0 && px == 0);
  endtask

  // Waits for result_valid after the last sample; optionally sprays inputs during SCAN.
  task automatic waitResult(input logic junk, output int lat);
    @(negedge clk);
    wr_en = 1'b0; sync = 1'b0; data = '0;
    lat = 1;
    checkOutput("in_ready_drop", {63'd0, in_ready}, 64'd0);
    while (!result_valid && lat < 2000) begin
      if (junk) begin
        wr_en = 1'b1;
        sync  = 1'($urandom_range(0, 1));
        data  = 10'($urandom_range(1, 1023));
      end
      @(negedge clk);
      lat++;
    end
    wr_en = 1'b0; sync = 1'b0; data = '0;
  endtask

  task automatic runFrame(input logic [2:0][3:0][9:0] p, input logic first_sync, input logic junk,
                          input logic [23:0] ebin, input logic [23:0] ecnt, input logic [2:0] esat);
    int lat;
    applyStimulus(p, first_sync);
    waitResult(junk, lat);
    checkOutput("latency", 64'(lat), 64'(LATENCY));
    checkOutput("peak_bin", {40'd0, peak_bin}, {40'd0, ebin});
    checkOutput("peak_cnt", {40'd0, peak_cnt}, {40'd0, ecnt});
    checkOutput("sat_flag", {61'd0, sat_flag}, {61'd0, esat});
    checkOutput("in_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    checkOutput("rv_pulse", {63'd0, result_valid}, 64'd0);
    checkOutput("peak_hold", {40'd0, peak_bin}, {40'd0, ebin});
  endtask

  initial begin
    int pulses;
    res = 1'b1; wr_en = 1'b0; sync = 1'b0; data = '0;
    zero_frame = '0;

    tbl[0].p[0] = {4{10'd108}}; tbl[0].p[1] = {4{10'd511}}; tbl[0].p[2] = {4{10'd1022}};
    tbl[0].ebin = {8'd255, 8'd127, 8'd27}; tbl[0].ecnt = {8'd4, 8'd4, 8'd4}; tbl[0].esat = 3'b000;

    tbl[1].p[0] = {4{10'd108}}; tbl[1].p[1] = {4{10'd0}}; tbl[1].p[2] = {4{10'd1022}};
    tbl[1].ebin = {8'd255, 8'd0, 8'd27}; tbl[1].ecnt = {8'd4, 8'd0, 8'd4}; tbl[1].esat = 3'b000;

    tbl[2].p[0] = {4{10'd4}}; tbl[2].p[1] = {4{10'd8}};
    tbl[2].p[2] = {10'd800, 10'd800, 10'd400, 10'd400};
    tbl[2].ebin = {8'd100, 8'd2, 8'd1}; tbl[2].ecnt = {8'd2, 8'd4, 8'd4}; tbl[2].esat = 3'b000;

    tbl[3].p[0] = {10'd12, 10'd16, 10'd12, 10'd12};
    tbl[3].p[1] = {10'd3, 10'd1023, 10'd3, 10'd1023};
    tbl[3].p[2] = {10'd5, 10'd0, 10'd0, 10'd0};
    tbl[3].ebin = {8'd1, 8'd0, 8'd3}; tbl[3].ecnt = {8'd1, 8'd2, 8'd3}; tbl[3].esat = 3'b000;

    tbl[4].p[0] = {4{10'd40}}; tbl[4].p[1] = {4{10'd100}}; tbl[4].p[2] = {4{10'd200}};
    tbl[4].ebin = {8'd50, 8'd25, 8'd10}; tbl[4].ecnt = {8'd4, 8'd4, 8'd4}; tbl[4].esat = 3'b000;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_rv", {63'd0, result_valid}, 64'd0);
    checkOutput("rst_peak_bin", {40'd0, peak_bin}, 64'd0);
    checkOutput("rst_peak_cnt", {40'd0, peak_cnt}, 64'd0);
    checkOutput("rst_sat", {61'd0, sat_flag}, 64'd0);
    res = 1'b0;

    // Partial frame killed by reset must leave no trace in the first table frame.
    sendSample(10'd108, 1'b0); sendSample(10'd511, 1'b0); sendSample(10'd1022, 1'b0);
    sendSample(10'd108, 1'b0); sendSample(10'd511, 1'b0);
    @(negedge clk); wr_en = 1'b0; res = 1'b1;
    @(negedge clk); res = 1'b0;

    for (int i = 0; i < 5; i++) begin
      $display("[TB] table frame %0d", i);
      runFrame(tbl[i].p, 1'b0, 1'b0, tbl[i].ebin, tbl[i].ecnt, tbl[i].esat);
      if (i == 4) begin
        checkOutput("narrow_peak_cnt", {58'd0, peak_cnt2}, 64'h3F);
        checkOutput("narrow_sat", {61'd0, sat_flag2}, 64'd7);
        checkOutput("narrow_peak_bin0", {56'd0, peak_bin2[7:0]}, 64'd10);
      end
    end

    $display("[TB] reset mid-SCAN");
    applyStimulus(tbl[0].p, 1'b0);
    @(negedge clk); wr_en = 1'b0;
    repeat (100) @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    checkOutput("scanrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("scanrst_peak_cnt", {40'd0, peak_cnt}, 64'd0);
    checkOutput("scanrst_rv", {63'd0, result_valid}, 64'd0);
    res = 1'b0;
    pulses = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checkOutput("stale_rv", 64'(pulses), 64'd0);
    runFrame(tbl[0].p, 1'b0, 1'b0, tbl[0].ebin, tbl[0].ecnt, tbl[0].esat);

    $display("[TB] sync without sample after pixel 1");
    sendSample(10'd108, 1'b0); sendSample(10'd511, 1'b0);
    @(negedge clk); wr_en = 1'b0; sync = 1'b1;
    runFrame(tbl[0].p, 1'b0, 1'b0, tbl[0].ebin, {8'd4, 8'd5, 8'd5}, 3'b000);

    $display("[TB] sync with sample after pixel 1, inputs driven during SCAN");
    sendSample(10'd108, 1'b0); sendSample(10'd511, 1'b0);
    runFrame(tbl[0].p, 1'b1, 1'b1, tbl[0].ebin, {8'd4, 8'd5, 8'd5}, 3'b000);

    $display("[TB] empty frame after SCAN activity");
    runFrame(zero_frame, 1'b0, 1'b0, 24'd0, 24'd0, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
